// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with true-LRU replacement,
// a captured-address refill FSM, whole-cache flush and saturating hit/miss counters.
module icache_2way #(
    parameter int ADDR_W     = 10,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4,
    parameter int COUNT_W    = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cpu_read,
    input  logic [ADDR_W-1:0]                         cpu_address,
    output logic [31:0]                               cpu_instruction,
    output logic                                      cpu_busywait,
    input  logic                                      flush,
    output logic                                      mem_read,
    output logic [ADDR_W-3-$clog2(LINE_WORDS):0]      mem_address,
    input  logic                                      mem_busywait,
    input  logic [32*LINE_WORDS-1:0]                  mem_readblock,
    output logic [COUNT_W-1:0]                        hit_count,
    output logic [COUNT_W-1:0]                        miss_count
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int MA_W   = ADDR_W - 2 - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FLUSH} state_t;

    state_t r_state, w_next;

    logic [SETS-1:0]   r_vld0, r_vld1, r_lru;
    logic [TAG_W-1:0]  r_tag0 [SETS];
    logic [TAG_W-1:0]  r_tag1 [SETS];
    logic [LINE_W-1:0] r_dat0 [SETS];
    logic [LINE_W-1:0] r_dat1 [SETS];

    logic [MA_W-1:0]    r_mem_address;
    logic               r_mem_read;
    logic               r_victim;
    logic               r_flush_pend;
    logic [IDX_W-1:0]   r_set_cnt;
    logic [COUNT_W-1:0] r_hit_count, r_miss_count;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx, w_miss_idx;
    logic [TAG_W-1:0]  w_tag, w_miss_tag;
    logic              w_hit0, w_hit1, w_hit;
    logic [LINE_W-1:0] w_line;
    logic [31:0]       w_word;
    logic              w_req_hit, w_req_miss, w_fill;
    logic              w_unused_addr;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_unused_addr = ^cpu_address[1:0];
    assign w_off      = cpu_address[2 +: OFF_W];
    assign w_idx      = cpu_address[2+OFF_W +: IDX_W];
    assign w_tag      = cpu_address[ADDR_W-1 -: TAG_W];
    // The refill target lives in the registered memory address, so it cannot drift.
    assign w_miss_idx = r_mem_address[IDX_W-1:0];
    assign w_miss_tag = r_mem_address[MA_W-1 -: TAG_W];

    assign w_hit0 = r_vld0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1 = r_vld1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit  = w_hit0 || w_hit1;
    assign w_line = w_hit1 ? r_dat1[w_idx] : r_dat0[w_idx];
    assign w_word = w_line[{w_off, 5'd0} +: 32];
    assign w_fill = (r_state == S_REFILL) && !mem_busywait;

    assign mem_read    = r_mem_read;
    assign mem_address = r_mem_address;
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        cpu_busywait    = 1'b0;
        cpu_instruction = '0;
        w_req_hit       = 1'b0;
        w_req_miss      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next       = S_FLUSH;
                    cpu_busywait = cpu_read;
                end else if (cpu_read) begin
                    if (w_hit) begin
                        cpu_instruction = w_word;
                        w_req_hit       = 1'b1;
                    end else begin
                        cpu_busywait = 1'b1;
                        w_req_miss   = 1'b1;
                        w_next       = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                cpu_busywait = 1'b1;
                if (!mem_busywait) w_next = (r_flush_pend || flush) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                cpu_busywait = 1'b1;
                if (r_set_cnt == IDX_W'(SETS-1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld0        <= '0;
            r_vld1        <= '0;
            r_lru         <= '0;
            r_mem_address <= '0;
            r_mem_read    <= 1'b0;
            r_victim      <= 1'b0;
            r_flush_pend  <= 1'b0;
            r_set_cnt     <= '0;
            r_hit_count   <= '0;
            r_miss_count  <= '0;
        end else begin
            if (w_req_hit) begin
                r_lru[w_idx] <= w_hit0;
                r_hit_count  <= sat_inc(r_hit_count);
            end
            if (w_req_miss) begin
                r_mem_address <= {w_tag, w_idx};
                r_mem_read    <= 1'b1;
                r_victim      <= r_lru[w_idx];
                r_miss_count  <= sat_inc(r_miss_count);
            end
            if (w_fill) begin
                if (r_victim) r_vld1[w_miss_idx] <= 1'b1;
                else          r_vld0[w_miss_idx] <= 1'b1;
                r_lru[w_miss_idx] <= ~r_victim;
                r_mem_read        <= 1'b0;
                r_flush_pend      <= 1'b0;
            end else if (r_state == S_REFILL && flush) begin
                r_flush_pend <= 1'b1;
            end
            // One set is invalidated per cycle; the counter wraps back to 0 on exit.
            if (r_state == S_FLUSH) begin
                r_vld0[r_set_cnt] <= 1'b0;
                r_vld1[r_set_cnt] <= 1'b0;
                r_lru[r_set_cnt]  <= 1'b0;
                r_set_cnt         <= r_set_cnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (r_victim) begin
                r_tag1[w_miss_idx] <= w_miss_tag;
                r_dat1[w_miss_idx] <= mem_readblock;
            end else begin
                r_tag0[w_miss_idx] <= w_miss_tag;
                r_dat0[w_miss_idx] <= mem_readblock;
            end
        end
    end
endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: transaction-level LRU cache model checked every cycle,
// plus directed fetch/flush/reset scenarios with hand-computed expectations.
module tb_icache_2way;
    localparam int ADDR_W     = 10;
    localparam int SETS       = 8;
    localparam int LINE_WORDS = 4;
    localparam int COUNT_W    = 4;
    localparam int MA_W       = 6;
    localparam int CMAX       = (1 << COUNT_W) - 1;

    logic                 clk;
    logic                 reset;
    logic                 cpu_read;
    logic [ADDR_W-1:0]    cpu_address;
    logic [31:0]          cpu_instruction;
    logic                 cpu_busywait;
    logic                 flush;
    logic                 mem_read;
    logic [MA_W-1:0]      mem_address;
    logic                 mem_busywait;
    logic [32*LINE_WORDS-1:0] mem_readblock;
    logic [COUNT_W-1:0]   hit_count;
    logic [COUNT_W-1:0]   miss_count;

    icache_2way #(.ADDR_W(ADDR_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_address(cpu_address),
        .cpu_instruction(cpu_instruction), .cpu_busywait(cpu_busywait), .flush(flush),
        .mem_read(mem_read), .mem_address(mem_address), .mem_busywait(mem_busywait),
        .mem_readblock(mem_readblock), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents: word w of line L is (L<<8) | (w*0x11).
    function automatic logic [31:0] word_of(input int line, input int w);
        return 32'((line << 8) | (w * 32'h11));
    endfunction

    function automatic int line_of(input logic [ADDR_W-1:0] a);
        return int'(a) >> 4;
    endfunction

    function automatic int woff_of(input logic [ADDR_W-1:0] a);
        return (int'(a) >> 2) & 3;
    endfunction

    always_comb begin
        mem_readblock = '0;
        for (int w = 0; w < LINE_WORDS; w++)
            mem_readblock[w*32 +: 32] = word_of(int'(mem_address), w);
    end

    int mem_lat = 0;
    int mem_cnt = 0;
    initial begin
        mem_busywait = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_read) begin
                if (mem_cnt < mem_lat) begin
                    mem_busywait = 1'b1;
                    mem_cnt++;
                end else begin
                    mem_busywait = 1'b0;
                end
            end else begin
                mem_cnt      = 0;
                mem_busywait = 1'b1;
            end
        end
    end

    // Model: resident lines keyed by line address, valued by last-use time.
    int m_res [int];
    int m_tick = 0;
    int m_mode = 0;
    int m_cap  = 0;
    int m_fcnt = 0;
    bit m_pend = 1'b0;
    int m_hit  = 0;
    int m_miss = 0;
    int mln, mn, mold, moldt;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_res.delete();
            m_mode = 0; m_pend = 1'b0; m_hit = 0; m_miss = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (flush) begin
                        m_mode = 2; m_fcnt = 0;
                    end else if (cpu_read) begin
                        mln = line_of(cpu_address);
                        if (m_res.exists(mln)) begin
                            m_tick++; m_res[mln] = m_tick;
                            if (m_hit < CMAX) m_hit++;
                        end else begin
                            m_cap = mln;
                            if (m_miss < CMAX) m_miss++;
                            m_mode = 1;
                        end
                    end
                end
                1: begin
                    if (!mem_busywait) begin
                        mn = 0; mold = -1; moldt = 0;
                        foreach (m_res[k]) begin
                            if ((k % SETS) == (m_cap % SETS)) begin
                                mn++;
                                if (mold < 0 || m_res[k] < moldt) begin
                                    mold = k; moldt = m_res[k];
                                end
                            end
                        end
                        if (mn >= 2) m_res.delete(mold);
                        m_tick++; m_res[m_cap] = m_tick;
                        m_mode = (m_pend || flush) ? 2 : 0;
                        m_fcnt = 0; m_pend = 1'b0;
                    end else if (flush) begin
                        m_pend = 1'b1;
                    end
                end
                default: begin
                    m_fcnt++;
                    if (m_fcnt == SETS) begin
                        m_res.delete(); m_mode = 0;
                    end
                end
            endcase
        end
    end

    bit c_hit;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            case (m_mode)
                0: begin
                    c_hit = m_res.exists(line_of(cpu_address));
                    if (flush) chk("m_busy_flushreq", cpu_busywait, cpu_read);
                    else       chk("m_busy_idle", cpu_busywait, cpu_read && !c_hit);
                    if (!cpu_read)
                        chk("m_instr_idle", cpu_instruction, 0);
                    else if (!flush && c_hit)
                        chk("m_instr_hit", cpu_instruction,
                            word_of(line_of(cpu_address), woff_of(cpu_address)));
                    chk("m_memrd_idle", mem_read, 0);
                end
                1: begin
                    chk("m_busy_refill", cpu_busywait, 1);
                    chk("m_memrd_refill", mem_read, 1);
                    chk("m_memaddr", mem_address, m_cap);
                end
                default: begin
                    chk("m_busy_flush", cpu_busywait, 1);
                    chk("m_memrd_flush", mem_read, 0);
                end
            endcase
            chk("m_hit_count", hit_count, m_hit);
            chk("m_miss_count", miss_count, m_miss);
        end
    end

    task automatic fetch(input logic [ADDR_W-1:0] a, input int fat,
                         output logic [31:0] ins, output int nb);
        bit done;
        done = 1'b0; nb = 0; ins = '0;
        cpu_address = a; cpu_read = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cpu_busywait) begin
                ins = cpu_instruction; done = 1'b1;
                break;
            end
            nb++;
            @(posedge clk); #1;
            flush = (nb == fat);
        end
        if (!done) chk("fetch_timeout", 0, 1);
        @(posedge clk); #1;
        flush = 1'b0; cpu_read = 1'b0;
    endtask

    logic [31:0] ins;
    int nb, nf;

    initial begin
        reset = 1'b1; cpu_read = 1'b0; cpu_address = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", cpu_busywait, 0);
        chk("rst_instr", cpu_instruction, 0);
        chk("rst_memrd", mem_read, 0);
        chk("rst_memaddr", mem_address, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        @(posedge clk); #1;

        mem_lat = 3;
        fetch(10'h000, -1, ins, nb);
        chk("cold_busy", nb, 5);
        chk("cold_instr", ins, 32'h00);
        chk("cold_miss", miss_count, 1);
        chk("cold_memaddr", mem_address, 0);
        fetch(10'h00C, -1, ins, nb);
        chk("hit_busy", nb, 0);
        chk("hit_instr", ins, 32'h33);
        chk("hit_count2", hit_count, 2);

        mem_lat = 0;
        fetch(10'h080, -1, ins, nb);
        chk("conf_080_busy", nb, 2);
        chk("conf_080_instr", ins, 32'h800);
        fetch(10'h004, -1, ins, nb);
        chk("conf_000_busy", nb, 0);
        chk("conf_000_instr", ins, 32'h11);
        fetch(10'h100, -1, ins, nb);
        chk("conf_100_busy", nb, 2);
        chk("conf_100_instr", ins, 32'h1000);
        fetch(10'h008, -1, ins, nb);
        chk("conf_keep000_busy", nb, 0);
        chk("conf_keep000_instr", ins, 32'h22);
        fetch(10'h084, -1, ins, nb);
        chk("conf_evict080_busy", nb, 2);
        chk("conf_evict080_instr", ins, 32'h811);
        chk("conf_miss", miss_count, 4);
        chk("conf_hit", hit_count, 7);

        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        nf = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cpu_busywait) break;
            nf++;
        end
        chk("flush_busy", nf, 8);
        @(posedge clk); #1;
        fetch(10'h000, -1, ins, nb);
        chk("postflush_busy", nb, 2);
        chk("postflush_miss", miss_count, 5);
        chk("postflush_hit", hit_count, 8);

        mem_lat = 4;
        fetch(10'h040, 2, ins, nb);
        chk("flushref_busy", nb, 20);
        chk("flushref_instr", ins, 32'h400);
        chk("flushref_miss", miss_count, 7);

        mem_lat = 10;
        cpu_address = 10'h200; cpu_read = 1'b1;
        repeat (3) @(negedge clk);
        chk("midref_memrd", mem_read, 1);
        @(posedge clk); #1;
        reset = 1'b1; cpu_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstref_memrd", mem_read, 0);
        chk("rstref_hits", hit_count, 0);
        chk("rstref_misses", miss_count, 0);
        @(posedge clk); #1;
        mem_lat = 0;
        fetch(10'h200, -1, ins, nb);
        chk("rstref_refetch_busy", nb, 2);
        chk("rstref_refetch_instr", ins, 32'h2000);

        for (int i = 0; i < 20; i++) fetch(10'h204, -1, ins, nb);
        chk("sat_instr", ins, 32'h2011);
        chk("sat_hits", hit_count, 15);
        chk("sat_misses", miss_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
